// File: rtl/axi_pkg.sv
// AXI response encodings shared by AXI/AXI-Lite endpoints.
package axi_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/idma_lite_sub_mem_pkg.sv
// Helpers for the iDMA AXI-Lite memory subordinate: address window decode.
package idma_lite_sub_mem_pkg;

  // Addresses are widened to 64 bits so the window end never overflows.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] span);
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/idma_lite_sub_sram.sv
// Byte-lane memory: one byte-enabled write port, one registered read port.
// A read and write to the same word in one cycle returns the old data.
module idma_lite_sub_sram #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumWords  = 256,
  parameter int unsigned StrbWidth = DataWidth / 8,
  parameter int unsigned IdxWidth  = $clog2(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [IdxWidth-1:0]  waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [StrbWidth-1:0] wstrb_i,
  input  logic                 re_i,
  input  logic [IdxWidth-1:0]  raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  // One narrow array per byte lane keeps each lane a plain block RAM.
  for (genvar gi = 0; gi < StrbWidth; gi++) begin : g_lane
    logic [7:0] r_mem [NumWords];
    logic [7:0] r_q;

    always_ff @(posedge clk_i) begin
      if (we_i && wstrb_i[gi]) begin
        r_mem[waddr_i] <= wdata_i[gi*8 +: 8];
      end
      if (re_i) begin
        r_q <= r_mem[raddr_i];
      end
    end

    assign rdata_o[gi*8 +: 8] = r_q;
  end

endmodule

// File: rtl/idma_lite_sub_mem.sv
// AXI-Lite subordinate backed by byte-writable memory; out-of-range -> SLVERR.
// Optional IDMA_LITE_SUB_ERR_INJ_EN adds inject_wr_err_i / inject_rd_err_i.
module idma_lite_sub_mem
  import axi_pkg::*;
  import idma_lite_sub_mem_pkg::*;
#(
  parameter int unsigned          DataWidth   = 32,
  parameter int unsigned          AddrWidth   = 32,
  parameter int unsigned          NumWords    = 256,
  parameter logic [AddrWidth-1:0] BaseAddr    = '0,
  parameter int unsigned          StrbWidth   = DataWidth / 8,
  parameter int unsigned          OffsetWidth = $clog2(StrbWidth),
  parameter int unsigned          IdxWidth    = $clog2(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic [2:0]           aw_prot_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [DataWidth-1:0] w_data_i,
  input  logic [StrbWidth-1:0] w_strb_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  output logic [1:0]           b_resp_o,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [2:0]           ar_prot_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_valid_o,
  input  logic                 r_ready_i
`ifdef IDMA_LITE_SUB_ERR_INJ_EN
  ,
  input  logic                 inject_wr_err_i,
  input  logic                 inject_rd_err_i
`endif
);

  localparam logic [63:0] MemBytes = 64'(NumWords) * 64'(StrbWidth);

  logic                 r_aw_full, r_w_full, r_b_valid, r_r_valid, r_rd_ok;
  logic [AddrWidth-1:0] r_aw_addr;
  logic [DataWidth-1:0] r_w_data;
  logic [StrbWidth-1:0] r_w_strb;
  resp_t                r_b_resp, r_r_resp;

  logic                 w_aw_hs, w_w_hs, w_ar_hs, w_wr_commit;
  logic                 w_inj_wr, w_inj_rd, w_wr_ok, w_rd_ok;
  logic [AddrWidth-1:0] w_wr_off, w_rd_off;
  logic [IdxWidth-1:0]  w_wr_idx, w_rd_idx;
  logic [DataWidth-1:0] w_rdata;
  logic                 w_unused_prot;

`ifdef IDMA_LITE_SUB_ERR_INJ_EN
  assign w_inj_wr = inject_wr_err_i;
  assign w_inj_rd = inject_rd_err_i;
`else
  assign w_inj_wr = 1'b0;
  assign w_inj_rd = 1'b0;
`endif

  assign w_unused_prot = ^{aw_prot_i, ar_prot_i};

  assign w_wr_commit = r_aw_full & r_w_full & (~r_b_valid | b_ready_i);
  assign aw_ready_o  = ~r_aw_full | w_wr_commit;
  assign w_ready_o   = ~r_w_full | w_wr_commit;
  assign ar_ready_o  = ~r_r_valid | r_ready_i;

  assign w_aw_hs = aw_valid_i & aw_ready_o;
  assign w_w_hs  = w_valid_i & w_ready_o;
  assign w_ar_hs = ar_valid_i & ar_ready_o;

  // Word index drops the byte offset; bits above the window are masked by decode.
  assign w_wr_off = r_aw_addr - BaseAddr;
  assign w_rd_off = ar_addr_i - BaseAddr;
  assign w_wr_idx = IdxWidth'(w_wr_off >> OffsetWidth);
  assign w_rd_idx = IdxWidth'(w_rd_off >> OffsetWidth);

  assign w_wr_ok = addr_in_range(64'(r_aw_addr), 64'(BaseAddr), MemBytes) & ~w_inj_wr;
  assign w_rd_ok = addr_in_range(64'(ar_addr_i), 64'(BaseAddr), MemBytes) & ~w_inj_rd;

  idma_lite_sub_sram #(
    .DataWidth (DataWidth),
    .NumWords  (NumWords)
  ) i_sram (
    .clk_i   (clk_i),
    .we_i    (w_wr_commit & w_wr_ok),
    .waddr_i (w_wr_idx),
    .wdata_i (r_w_data),
    .wstrb_i (r_w_strb),
    .re_i    (w_ar_hs & w_rd_ok),
    .raddr_i (w_rd_idx),
    .rdata_o (w_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_b_valid <= 1'b0;
      r_b_resp  <= RESP_OKAY;
      r_r_valid <= 1'b0;
      r_r_resp  <= RESP_OKAY;
      r_rd_ok   <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= aw_addr_i;
      end else if (w_wr_commit) begin
        r_aw_full <= 1'b0;
      end

      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= w_data_i;
        r_w_strb <= w_strb_i;
      end else if (w_wr_commit) begin
        r_w_full <= 1'b0;
      end

      if (w_wr_commit) begin
        r_b_valid <= 1'b1;
        r_b_resp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (b_ready_i) begin
        r_b_valid <= 1'b0;
      end

      if (w_ar_hs) begin
        r_r_valid <= 1'b1;
        r_r_resp  <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
        r_rd_ok   <= w_rd_ok;
      end else if (r_ready_i) begin
        r_r_valid <= 1'b0;
      end
    end
  end

  assign b_valid_o = r_b_valid;
  assign b_resp_o  = r_b_resp;
  assign r_valid_o = r_r_valid;
  assign r_resp_o  = r_r_resp;
  // The SRAM output only changes on an accepted read, so R stays stable while stalled.
  assign r_data_o  = r_rd_ok ? w_rdata : '0;

endmodule

// File: tb/tb_idma_lite_sub_mem.sv
// Scoreboard bench for idma_lite_sub_mem: directed writes/reads, monitor checks B and R.
module tb_idma_lite_sub_mem;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] aw_addr, ar_addr, w_data, r_data;
  logic [3:0]  w_strb;
  logic        aw_valid, aw_ready, w_valid, w_ready, ar_valid, ar_ready;
  logic        b_valid, b_ready, r_valid, r_ready;
  logic [1:0]  b_resp, r_resp;
`ifdef IDMA_LITE_SUB_ERR_INJ_EN
  logic        inj_wr, inj_rd;
`endif

  always #5 clk = ~clk;

  idma_lite_sub_mem dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .aw_addr_i  (aw_addr),
    .aw_prot_i  (3'b000),
    .aw_valid_i (aw_valid),
    .aw_ready_o (aw_ready),
    .w_data_i   (w_data),
    .w_strb_i   (w_strb),
    .w_valid_i  (w_valid),
    .w_ready_o  (w_ready),
    .b_resp_o   (b_resp),
    .b_valid_o  (b_valid),
    .b_ready_i  (b_ready),
    .ar_addr_i  (ar_addr),
    .ar_prot_i  (3'b000),
    .ar_valid_i (ar_valid),
    .ar_ready_o (ar_ready),
    .r_data_o   (r_data),
    .r_resp_o   (r_resp),
    .r_valid_o  (r_valid),
    .r_ready_i  (r_ready)
`ifdef IDMA_LITE_SUB_ERR_INJ_EN
    ,
    .inject_wr_err_i (inj_wr),
    .inject_rd_err_i (inj_rd)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare whatever B/R presents against the scoreboard head; pop on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (b_valid) begin
        if (exp_b.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b_unexpected: got resp %0d, expected no response", b_resp);
        end else begin
          chk("b_resp", 64'(b_resp), 64'(exp_b[0]));
          if (b_ready) begin
            $display("B  resp=%0d", b_resp);
            void'(exp_b.pop_front());
          end
        end
      end
      if (r_valid) begin
        if (exp_r.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL r_unexpected: got data 0x%0h, expected no response", r_data);
        end else begin
          chk("r_beat", 64'({r_resp, r_data}), 64'(exp_r[0]));
          if (r_ready) begin
            $display("R  data=0x%08h resp=%0d", r_data, r_resp);
            void'(exp_r.pop_front());
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic aw_hs(input logic [31:0] a);
    bit ok = 0;
    aw_addr = a; aw_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (aw_ready) begin ok = 1; break; end
    end
    if (!ok) begin n_checks++; n_fail++; $display("FAIL aw_timeout: got no aw_ready, expected one"); end
    @(posedge clk); #1;
    aw_valid = 1'b0;
  endtask

  task automatic w_hs(input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    w_data = d; w_strb = s; w_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (w_ready) begin ok = 1; break; end
    end
    if (!ok) begin n_checks++; n_fail++; $display("FAIL w_timeout: got no w_ready, expected one"); end
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic ar_hs(input logic [31:0] a);
    bit ok = 0;
    ar_addr = a; ar_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ar_ready) begin ok = 1; break; end
    end
    if (!ok) begin n_checks++; n_fail++; $display("FAIL ar_timeout: got no ar_ready, expected one"); end
    @(posedge clk); #1;
    ar_valid = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] resp);
    exp_b.push_back(resp);
    fork
      aw_hs(a);
      w_hs(d, s);
    join
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    exp_r.push_back({resp, d});
    ar_hs(a);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp_b.size() == 0 && exp_r.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL drain: got %0d B / %0d R outstanding, expected 0", exp_b.size(), exp_r.size());
    end
    idle(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    aw_valid = 0; w_valid = 0; ar_valid = 0;
    aw_addr = '0; ar_addr = '0; w_data = '0; w_strb = '0;
    b_ready = 1'b1; r_ready = 1'b1;
`ifdef IDMA_LITE_SUB_ERR_INJ_EN
    inj_wr = 1'b0; inj_rd = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_aw_ready", 64'(aw_ready), 64'd1);
    chk("rst_w_ready",  64'(w_ready),  64'd1);
    chk("rst_ar_ready", 64'(ar_ready), 64'd1);
    chk("rst_b_valid",  64'(b_valid),  64'd0);
    chk("rst_r_valid",  64'(r_valid),  64'd0);
    chk("rst_resps",    64'({b_resp, r_resp}), 64'd0);
    chk("rst_r_data",   64'(r_data),   64'd0);
    @(posedge clk); #1 rst = 1'b0;
    idle(1);

    wr(32'h0000_0000, 32'hCAFE_F00D, 4'hF, RESP_OKAY);
    wr(32'h0000_0060, 32'h600D_600D, 4'hF, RESP_OKAY);
    drain();

    // Basic write then read with latency checks.
    wr(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, RESP_OKAY);
    @(negedge clk); chk("t1_b_commit_cycle", 64'(b_valid), 64'd0);
    @(negedge clk); chk("t1_b_at_n2", 64'(b_valid), 64'd1);
    idle(1);
    rd(32'h0000_0010, 32'hDEAD_BEEF, RESP_OKAY);
    @(negedge clk); chk("t1_r_latency", 64'(r_valid), 64'd1);
    idle(1);
    drain();

    // Partial strobes, then all-zero strobe leaves memory untouched.
    wr(32'h0000_0020, 32'h1122_3344, 4'hF, RESP_OKAY);
    wr(32'h0000_0020, 32'hAABB_CCDD, 4'b0101, RESP_OKAY);
    idle(2);
    rd(32'h0000_0020, 32'h11BB_33DD, RESP_OKAY);
    wr(32'h0000_0020, 32'hFFFF_FFFF, 4'h0, RESP_OKAY);
    idle(2);
    rd(32'h0000_0020, 32'h11BB_33DD, RESP_OKAY);
    drain();

    // Read in the commit cycle of a write to the same word sees the old data.
    wr(32'h0000_0024, 32'h0000_1111, 4'hF, RESP_OKAY);
    idle(2);
    wr(32'h0000_0024, 32'h0000_2222, 4'hF, RESP_OKAY);
    rd(32'h0000_0024, 32'h0000_1111, RESP_OKAY);
    rd(32'h0000_0024, 32'h0000_2222, RESP_OKAY);
    drain();

    // AW first, W three cycles later.
    exp_b.push_back(RESP_OKAY);
    aw_hs(32'h0000_0030);
    @(negedge clk);
    chk("t3_aw_ready_held", 64'(aw_ready), 64'd0);
    chk("t3_w_ready_free",  64'(w_ready),  64'd1);
    idle(2);
    w_hs(32'h3333_0003, 4'hF);
    @(negedge clk);
    chk("t3_b_commit_cycle", 64'(b_valid), 64'd0);
    chk("t3_aw_ready_commit", 64'(aw_ready), 64'd1);
    @(negedge clk); chk("t3_b_valid", 64'(b_valid), 64'd1);
    idle(1);
    rd(32'h0000_0030, 32'h3333_0003, RESP_OKAY);
    drain();

    // Out of range (aliases word 0 if decode is wrong) and top in-range word.
    wr(32'h0000_0400, 32'hBAD0_BAD0, 4'hF, RESP_SLVERR);
    wr(32'h0000_03FC, 32'h0000_03FC, 4'hF, RESP_OKAY);
    idle(2);
    rd(32'h0000_0400, 32'h0000_0000, RESP_SLVERR);
    rd(32'h0000_0000, 32'hCAFE_F00D, RESP_OKAY);
    rd(32'h0000_03FC, 32'h0000_03FC, RESP_OKAY);
    drain();

    // Stream 8 writes with B stalled, then 8 reads with r_ready toggling.
    b_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          wr(32'h100 + 32'(4 * i), 32'hA500_0000 | 32'(i), 4'hF, RESP_OKAY);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("stall_aw_ready", 64'(aw_ready), 64'd0);
        chk("stall_w_ready",  64'(w_ready),  64'd0);
        @(posedge clk); #1;
        b_ready = 1'b1;
      end
    join
    drain();
    fork
      begin
        for (int i = 0; i < 8; i++)
          rd(32'h100 + 32'(4 * i), 32'hA500_0000 | 32'(i), RESP_OKAY);
      end
      begin
        for (int j = 0; j < 30; j++) begin
          @(posedge clk); #1;
          r_ready = ~r_ready;
        end
        r_ready = 1'b1;
      end
    join
    drain();

    // Reset with a held AW: it must not pair with the next W.
    aw_hs(32'h0000_0060);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk); chk("mid_rst_aw_ready", 64'(aw_ready), 64'd1);
    idle(1);
    wr(32'h0000_0064, 32'h6464_6464, 4'hF, RESP_OKAY);
    idle(2);
    rd(32'h0000_0060, 32'h600D_600D, RESP_OKAY);
    rd(32'h0000_0064, 32'h6464_6464, RESP_OKAY);
    drain();

`ifdef IDMA_LITE_SUB_ERR_INJ_EN
    wr(32'h0000_0008, 32'h1234_5678, 4'hF, RESP_OKAY);
    idle(2);
    inj_wr = 1'b1;
    wr(32'h0000_0008, 32'h0000_0005, 4'hF, RESP_SLVERR);
    idle(3);
    inj_wr = 1'b0;
    rd(32'h0000_0008, 32'h1234_5678, RESP_OKAY);
    inj_rd = 1'b1;
    rd(32'h0000_0008, 32'h0000_0000, RESP_SLVERR);
    inj_rd = 1'b0;
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
